seq_div_32by16: RTL and testbench

//  Sequential unsigned restoring divider: 2*W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.

---
 rtl/seq_div_32by16.sv | 113 +++++++++++
 tb/tb_seq_div_32by16.sv | 139 +++++++++++++
 2 files changed

// File: rtl/seq_div_32by16.sv
// seq_div_32by16 - sequential restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock
// The accept edge retires the first quotient bit so a full job reports done W cycles after start.
module seq_div_32by16 #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf,
  output logic           dz
);

  localparam int CW = $clog2(W);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 2);

  logic [1:0]    state;
  logic [W-1:0]  r;
  logic [W-1:0]  q;
  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;

  logic [W-1:0]  src_r;
  logic [W-1:0]  src_q;
  logic [W-1:0]  src_d;
  logic [W:0]    shifted;
  logic [W+1:0]  diff;
  logic [W-1:0]  step_r;
  logic [W-1:0]  step_q;
  logic          hi_ge;

  // In IDLE the step datapath looks at the raw inputs so the accept edge retires bit W-1.
  always_comb begin
    src_r   = (state == S_IDLE) ? dividend[2*W-1:W] : r;
    src_q   = (state == S_IDLE) ? dividend[W-1:0]   : q;
    src_d   = (state == S_IDLE) ? divisor           : dvs;
    shifted = {src_r, src_q[W-1]};
    diff    = {1'b0, shifted} - {2'b00, src_d};
    step_r  = shifted[W-1:0];
    step_q  = {src_q[W-2:0], 1'b0};
    if (!diff[W+1]) begin
      step_r = diff[W-1:0];
      step_q = {src_q[W-2:0], 1'b1};
    end
  end

  assign hi_ge = (dividend[2*W-1:W] >= divisor);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      r         <= '0;
      q         <= '0;
      dvs       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend[W-1:0];
              dz        <= 1'b1;
              ovf       <= 1'b0;
              state     <= S_DONE;
            end else if (hi_ge) begin
              quotient  <= '1;
              remainder <= dividend[W-1:0];
              dz        <= 1'b0;
              ovf       <= 1'b1;
              state     <= S_DONE;
            end else begin
              r     <= step_r;
              q     <= step_q;
              dvs   <= divisor;
              cnt   <= '0;
              ovf   <= 1'b0;
              dz    <= 1'b0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r   <= step_r;
          q   <= step_q;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            quotient  <= step_q;
            remainder <= step_r;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_32by16.sv
// tb_seq_div_32by16 - directed and randomized checks of seq_div_32by16 against an arithmetic model
module tb_seq_div_32by16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        ovf;
  logic        dz;

  int total = 0;
  int bad   = 0;

  seq_div_32by16 #(.W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is #1 after a rising edge with the DUT in IDLE.
  task automatic job(input logic [31:0] a, input logic [15:0] b, input int inj, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic        eo;
    logic        ez;
    int          exp_lat;
    int          lat;
    ez = (b == 16'd0);
    eo = !ez && (a[31:16] >= b);
    if (ez || eo) begin
      eq = 32'h0000_FFFF;
      er = {16'd0, a[15:0]};
      exp_lat = 1;
    end else begin
      eq = a / {16'd0, b};
      er = a % {16'd0, b};
      exp_lat = 16;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    lat = 1;
    if (exp_lat == 16) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && lat < 40) begin
      if (lat == inj) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_q"}, {16'd0, quotient}, eq);
    chk({tag, "_r"}, {16'd0, remainder}, er);
    chk({tag, "_flags"}, {30'd0, ovf, dz}, {30'd0, eo, ez});
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] rm;
    int          dones;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, ovf, dz, quotient, remainder}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    job(32'h0000_0C00, 16'h0030, -1, "t_c00");
    job(32'hFFFE_0001, 16'hFFFF, -1, "t_maxok");
    job(32'h0001_0000, 16'h0003, 5, "t_restart");
    job(32'h1234_5678, 16'h0000, -1, "t_dz");
    job(32'h0002_0000, 16'h0002, -1, "t_ovf");
    job(32'h0000_0000, 16'h0000, -1, "t_dz_zero");
    job(32'h0000_FFFF, 16'h0001, -1, "t_div1");
    job(32'hFFFF_FFFF, 16'hFFFF, -1, "t_ovf_max");

    // Reset in cycle 8 of a job: outputs clear and the aborted job never completes.
    dividend = 32'h0001_0000; divisor = 16'h0003; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_clear", {busy, done, ovf, dz, quotient, remainder}, 32'd0);
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);
    job(32'h0001_0000, 16'h0003, -1, "t_fresh");

    for (int i = 0; i < 2000; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom_range(1, 65535));
      rm = 16'($urandom_range(0, b - 1));
      job({16'd0, a} * {16'd0, b} + {16'd0, rm}, b, -1, "rand_ab");
    end
    for (int i = 0; i < 200; i++) begin
      b = (i % 10 == 0) ? 16'd0 : 16'($urandom);
      job($urandom, b, -1, "rand_any");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
